// File: rtl/vx_gbar_ctrl_pkg.sv
// Shared types for the cluster global barrier controller.
// Widths derive from the cluster core count and the number of barrier IDs.
package vx_gbar_ctrl_pkg;

  localparam int GBAR_NUM_CORES    = 4;
  localparam int GBAR_NUM_BARRIERS = 8;
  localparam int GBAR_NC_WIDTH     = $clog2(GBAR_NUM_CORES);
  localparam int GBAR_NB_WIDTH     = $clog2(GBAR_NUM_BARRIERS);

  typedef struct packed {
    logic [GBAR_NB_WIDTH-1:0] id;
    logic [GBAR_NC_WIDTH-1:0] size_m1;
    logic [GBAR_NC_WIDTH-1:0] core_id;
  } gbar_req_t;

  typedef struct packed {
    logic [GBAR_NB_WIDTH-1:0] id;
  } gbar_rsp_t;

  // Arrival count that completes a barrier of the given size, one bit wider than size_m1.
  function automatic logic [GBAR_NC_WIDTH:0] gbar_target(input logic [GBAR_NC_WIDTH-1:0] size_m1);
    return {1'b0, size_m1} + (GBAR_NC_WIDTH+1)'(1);
  endfunction

endpackage

// File: rtl/vx_gbar_ctrl_if.sv
// Core-scheduler <-> barrier-controller bus: per-core arrival requests with ready
// grants, plus a broadcast one-cycle release response with no backpressure.
interface vx_gbar_ctrl_if #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int NC_WIDTH     = $clog2(NUM_CORES),
  parameter int NB_WIDTH     = $clog2(NUM_BARRIERS)
);
  logic [NUM_CORES-1:0]               req_valid;
  logic [NUM_CORES-1:0][NB_WIDTH-1:0] req_id;
  logic [NUM_CORES-1:0][NC_WIDTH-1:0] req_size_m1;
  logic [NUM_CORES-1:0]               req_ready;
  logic                               rsp_valid;
  logic [NB_WIDTH-1:0]                rsp_id;

  modport master (
    output req_valid, req_id, req_size_m1,
    input  req_ready, rsp_valid, rsp_id
  );

  modport slave (
    input  req_valid, req_id, req_size_m1,
    output req_ready, rsp_valid, rsp_id
  );
endinterface

// File: rtl/vx_gbar_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the slot after the
// last accepted grant; the pointer moves only when grant_ready confirms acceptance.
module vx_gbar_ctrl_rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                grant_ready,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   slot;
  logic [IDX_W:0]   nxt;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    slot        = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      slot = {1'b0, ptr} + (IDX_W+1)'(i);
      if (slot >= (IDX_W+1)'(NUM_REQS)) slot = slot - (IDX_W+1)'(NUM_REQS);
      if (!grant_valid && req[slot[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = slot[IDX_W-1:0];
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    nxt = {1'b0, grant_idx} + (IDX_W+1)'(1);
    if (nxt == (IDX_W+1)'(NUM_REQS)) nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_valid && grant_ready) begin
      ptr <= nxt[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/vx_gbar_ctrl.sv
// Global barrier controller: one round-robin arrival per cycle, release pulse one cycle
// after the completing arrival; requesters stall on req_ready, releases are never stalled.
module vx_gbar_ctrl
  import vx_gbar_ctrl_pkg::*;
#(
  parameter int NUM_CORES    = GBAR_NUM_CORES,
  parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
  parameter int NC_WIDTH     = $clog2(NUM_CORES),
  parameter int NB_WIDTH     = $clog2(NUM_BARRIERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  vx_gbar_ctrl_if.slave           bus,
  output logic [NUM_BARRIERS-1:0] pending,
  output logic                    err_dup,
  output logic                    err_size,
  output logic                    busy
);

  logic [NUM_CORES-1:0] grant;
  logic [NC_WIDTH-1:0]  grant_idx;
  logic                 grant_valid;

  vx_gbar_ctrl_rr_arbiter #(
    .NUM_REQS (NUM_CORES)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (bus.req_valid),
    .grant_ready (1'b1),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign bus.req_ready = grant & {NUM_CORES{reset}};

  logic [NUM_CORES-1:0] arr_mask [NUM_BARRIERS];
  logic [NC_WIDTH-1:0]  arr_size [NUM_BARRIERS];
  logic [NC_WIDTH:0]    arr_cnt  [NUM_BARRIERS];

  gbar_req_t         cur;
  logic              first;
  logic              dup;
  logic              done;
  logic [NC_WIDTH-1:0] eff_size;
  logic [NC_WIDTH:0] new_cnt;

  always_comb begin
    cur.id      = bus.req_id[grant_idx];
    cur.size_m1 = bus.req_size_m1[grant_idx];
    cur.core_id = grant_idx;
    first       = (arr_cnt[cur.id] == '0);
    dup         = !first && arr_mask[cur.id][cur.core_id];
    // The first arrival defines the episode size; later arrivals are held to it.
    eff_size    = first ? cur.size_m1 : arr_size[cur.id];
    new_cnt     = arr_cnt[cur.id] + (NC_WIDTH+1)'(1);
    done        = (new_cnt == gbar_target(eff_size));
  end

  logic      rsp_valid_q;
  gbar_rsp_t rsp_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        arr_mask[b] <= '0;
        arr_size[b] <= '0;
        arr_cnt[b]  <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      err_dup     <= 1'b0;
      err_size    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (grant_valid) begin
        if (dup) begin
          err_dup <= 1'b1;
        end else begin
          if (!first && (cur.size_m1 != arr_size[cur.id])) err_size <= 1'b1;
          if (done) begin
            // Clearing on the completing edge lets the next arrival open a fresh episode.
            arr_mask[cur.id] <= '0;
            arr_cnt[cur.id]  <= '0;
            rsp_valid_q      <= 1'b1;
            rsp_q.id         <= cur.id;
          end else begin
            arr_mask[cur.id][cur.core_id] <= 1'b1;
            arr_cnt[cur.id]               <= new_cnt;
            arr_size[cur.id]              <= eff_size;
          end
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BARRIERS; b++) pending[b] = (arr_cnt[b] != '0);
  end

  assign busy          = |pending;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_q.id;

endmodule

// File: tb/tb_vx_gbar_ctrl.sv
// Bench for vx_gbar_ctrl: scripted arrival scenarios with a release scoreboard checked
// every cycle against a small barrier model.
module tb_vx_gbar_ctrl;
  import vx_gbar_ctrl_pkg::*;

  localparam int NC = 4;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NB-1:0] pending;
  logic          err_dup, err_size, busy;

  vx_gbar_ctrl_if #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) bus ();

  vx_gbar_ctrl #(.NUM_CORES(NC), .NUM_BARRIERS(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pending  (pending),
    .err_dup  (err_dup),
    .err_size (err_size),
    .busy     (busy)
  );

  typedef struct {
    logic [2:0] id;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  int            m_cnt  [NB];
  int            m_size [NB];
  logic [NC-1:0] m_mask [NB];
  logic          m_dup, m_size_err;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic logic [NB-1:0] m_pending();
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = (m_cnt[b] != 0);
    return p;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      m_cnt[b]  = 0;
      m_size[b] = 0;
      m_mask[b] = '0;
    end
    m_dup      = 1'b0;
    m_size_err = 1'b0;
  endtask

  // Records an accepted arrival; a completing one schedules a release for the next cycle.
  task automatic model_accept(input int c, input int b, input int s);
    if (m_cnt[b] == 0) begin
      m_size[b] = s;
      m_mask[b] = '0;
    end else if (m_mask[b][c]) begin
      m_dup = 1'b1;
      return;
    end else if (s != m_size[b]) begin
      m_size_err = 1'b1;
    end
    m_mask[b][c] = 1'b1;
    m_cnt[b]     = m_cnt[b] + 1;
    if (m_cnt[b] == m_size[b] + 1) begin
      exp_q.push_back('{id: 3'(b), cyc: cyc + 1});
      m_cnt[b]  = 0;
      m_mask[b] = '0;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_q[0].id) begin
          fails++;
          $display("FAIL rsp_release cyc=%0d: got valid=%b id=%0d, want valid=1 id=%0d",
                   cyc, bus.rsp_valid, bus.rsp_id, exp_q[0].id);
        end
        void'(exp_q.pop_front());
      end else if (bus.rsp_valid !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected cyc=%0d: got valid=%b id=%0d, want valid=0",
                 cyc, bus.rsp_valid, bus.rsp_id);
      end
    end
  endtask

  task automatic set_req(input int c, input int b, input int s);
    bus.req_valid         = '0;
    bus.req_valid[c]      = 1'b1;
    bus.req_id[c]         = 3'(b);
    bus.req_size_m1[c]    = 2'(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    bus.req_valid   = '1;
    bus.req_id      = '0;
    bus.req_size_m1 = '0;
    model_clear();
    #2;
    tests++;
    if (bus.req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b, want 0000", bus.req_ready);
    end
    tests++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 3'd0) begin
      fails++; $display("FAIL reset_rsp: got valid=%b id=%0d, want 0/0", bus.rsp_valid, bus.rsp_id);
    end
    tests++;
    if (pending !== 8'h00 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_pending: got pending=%h busy=%b, want 00/0", pending, busy);
    end
    tests++;
    if (err_dup !== 1'b0 || err_size !== 1'b0) begin
      fails++; $display("FAIL reset_err: got dup=%b size=%b, want 0/0", err_dup, err_size);
    end
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 3, 0);
    #1;
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++; $display("FAIL single_ready: got %b, want 0100", bus.req_ready);
    end
    model_accept(2, 3, 0);
    @(negedge clk);
    bus.req_valid = '0;
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 3'd3) begin
      fails++; $display("FAIL single_rsp: got valid=%b id=%0d, want 1/3", bus.rsp_valid, bus.rsp_id);
    end
    tests++;
    if (pending !== 8'h00) begin
      fails++; $display("FAIL single_pending: got %h, want 00", pending);
    end
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b0 || err_dup !== 1'b0 || err_size !== 1'b0) begin
      fails++; $display("FAIL single_after: got rsp=%b dup=%b size=%b, want 0/0/0",
                        bus.rsp_valid, err_dup, err_size);
    end
  endtask

  task automatic test_all_cores();
    do_reset();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < NC; c++) begin
      bus.req_id[c]      = 3'd1;
      bus.req_size_m1[c] = 2'd3;
    end
    for (int k = 0; k < NC; k++) begin
      #1;
      tests++;
      if (bus.req_ready !== 4'(1 << k)) begin
        fails++; $display("FAIL rr_grant step %0d: got %b, want %b", k, bus.req_ready, 4'(1 << k));
      end
      tests++;
      if (pending[1] !== (k != 0)) begin
        fails++; $display("FAIL rr_pending step %0d: got %b, want %b", k, pending[1], k != 0);
      end
      model_accept(k, 1, 3);
      @(negedge clk);
      bus.req_valid[k] = 1'b0;
    end
    tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 3'd1 || pending !== 8'h00 || busy !== 1'b0) begin
      fails++; $display("FAIL rr_release: got valid=%b id=%0d pending=%h busy=%b, want 1/1/00/0",
                        bus.rsp_valid, bus.rsp_id, pending, busy);
    end
  endtask

  task automatic test_dup();
    int seq [4] = '{0, 0, 1, 2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(seq[i], 5, 2);
      #1;
      tests++;
      if (bus.req_ready !== 4'(1 << seq[i])) begin
        fails++; $display("FAIL dup_ready step %0d: got %b, want %b", i, bus.req_ready, 4'(1 << seq[i]));
      end
      model_accept(seq[i], 5, 2);
      @(negedge clk);
      bus.req_valid = '0;
      tests++;
      if (err_dup !== m_dup || pending !== m_pending()) begin
        fails++; $display("FAIL dup_state step %0d: got dup=%b pending=%h, want %b/%h",
                          i, err_dup, pending, m_dup, m_pending());
      end
    end
    tests++;
    if (err_dup !== 1'b1 || err_size !== 1'b0) begin
      fails++; $display("FAIL dup_flags: got dup=%b size=%b, want 1/0", err_dup, err_size);
    end
  endtask

  task automatic test_size_mismatch();
    int sz [2] = '{1, 3};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_req(i, 2, sz[i]);
      #1;
      tests++;
      if (bus.req_ready !== 4'(1 << i)) begin
        fails++; $display("FAIL size_ready step %0d: got %b, want %b", i, bus.req_ready, 4'(1 << i));
      end
      model_accept(i, 2, sz[i]);
      @(negedge clk);
      bus.req_valid = '0;
      tests++;
      if (err_size !== m_size_err || pending !== m_pending()) begin
        fails++; $display("FAIL size_state step %0d: got err=%b pending=%h, want %b/%h",
                          i, err_size, pending, m_size_err, m_pending());
      end
    end
    @(negedge clk);
    tests++;
    if (err_size !== 1'b1 || err_dup !== 1'b0) begin
      fails++; $display("FAIL size_sticky: got size=%b dup=%b, want 1/0", err_size, err_dup);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(1, 4, 1);
    #1;
    model_accept(1, 4, 1);
    @(negedge clk);
    set_req(2, 4, 1);
    #1;
    tests++;
    if (bus.req_ready !== 4'b0100) begin
      fails++; $display("FAIL b2b_ready0: got %b, want 0100", bus.req_ready);
    end
    model_accept(2, 4, 1);
    @(negedge clk);
    set_req(0, 4, 1);
    #1;
    tests++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 3'd4) begin
      fails++; $display("FAIL b2b_release_cycle: got ready=%b rsp=%b id=%0d, want 0001/1/4",
                        bus.req_ready, bus.rsp_valid, bus.rsp_id);
    end
    model_accept(0, 4, 1);
    @(negedge clk);
    bus.req_valid = '0;
    tests++;
    if (pending[4] !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_new_episode: got pending4=%b rsp=%b, want 1/0", pending[4], bus.rsp_valid);
    end
    set_req(3, 4, 1);
    #1;
    model_accept(3, 4, 1);
    @(negedge clk);
    bus.req_valid = '0;
    tests++;
    if (pending !== 8'h00) begin
      fails++; $display("FAIL b2b_second_release: got pending=%h, want 00", pending);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_req(i, 6, 3);
      #1;
      model_accept(i, 6, 3);
      @(negedge clk);
    end
    bus.req_valid = '0;
    tests++;
    if (pending !== 8'h40) begin
      fails++; $display("FAIL midrst_before: got pending=%h, want 40", pending);
    end
    set_req(2, 6, 3);
    reset = 1'b0;
    model_clear();
    #1;
    tests++;
    if (pending !== 8'h00 || busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
      fails++; $display("FAIL midrst_during: got pending=%h busy=%b ready=%b, want 00/0/0000",
                        pending, busy, bus.req_ready);
    end
    repeat (2) @(negedge clk);
    bus.req_valid = '0;
    reset = 1'b1;
    for (int i = 0; i < NC; i++) begin
      set_req(i, 6, 3);
      #1;
      tests++;
      if (bus.req_ready !== 4'(1 << i)) begin
        fails++; $display("FAIL midrst_ready step %0d: got %b, want %b", i, bus.req_ready, 4'(1 << i));
      end
      model_accept(i, 6, 3);
      @(negedge clk);
      bus.req_valid = '0;
      tests++;
      if (pending !== m_pending()) begin
        fails++; $display("FAIL midrst_pending step %0d: got %h, want %h", i, pending, m_pending());
      end
    end
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.req_id      = '0;
    bus.req_size_m1 = '0;
    test_reset();
    fork
      monitor();
    join_none
    test_single();
    test_all_cores();
    test_dup();
    test_size_mismatch();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL rsp_drain: got %0d releases outstanding, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
